// File: rtl/viterbi_tx_rx_2b7.sv
// viterbi_tx_rx_2b7 -- loopback FEC link.
// Chain: rate-1/2 K=7 convolutional encoder, then a channel that flips one
// bit at a fixed interval, then a hard-decision 64-state Viterbi decoder.
// A delay line after the decoder makes the latency exactly LATENCY cycles.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   encoder_i         information bit, sampled every rising edge
//   enable_encoder_i  1 = encode encoder_i, 0 = encode 0 (flush)
//   decoder_o         decoded information bit (registered)
//
// Timing: encoder_i sampled at edge n is the value of decoder_o sampled at
// edge n+LATENCY. The LATENCY outputs that follow a reset are 0.
//
// Internal pipeline, for an input bit sampled at edge j:
//   j                 encoder output XOR err_inj -> rx_q
//   j+1               ACS step; the survivor row goes into tb_mem_q
//   j+TB_DEPTH+2      traceback has reached the bit -> tb_bit_q
//   j+LATENCY-1       bit leaves the delay line -> decoder_o
module viterbi_tx_rx_2b7 #(
    parameter int LATENCY    = 4105,
    parameter int TB_DEPTH   = 48,
    parameter int ERR_PERIOD = 16,
    parameter bit ERR_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic encoder_i,
    input  logic enable_encoder_i,
    output logic decoder_o
);
    localparam int NS     = 64;
    localparam int TBM    = TB_DEPTH + 1;
    localparam int PTR_W  = $clog2(TBM);
    localparam int DL     = LATENCY - TB_DEPTH - 4;
    localparam int EP_LOG = $clog2(ERR_PERIOD);
    localparam logic [31:0] EP_M1 = 32'(ERR_PERIOD - 1);

    // Code symbol {c1,c0} for a state register sr and a new bit u.
    // Bit 6 of each tap word applies to u, bit 5 to the newest stored bit
    // (sr[0]) and bit 0 to the oldest (sr[5]). This is the standard
    // 171/133 code, which has dfree = 10.
    function automatic logic [1:0] enc_sym(input logic [5:0] sr, input logic u);
        logic [6:0] v;
        v = {u, sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]};
        return {^(v & 7'o133), ^(v & 7'o171)};
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] a);
        return {a[1] & a[0], a[1] ^ a[0]};
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] m, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, m} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // ---------------- encoder ----------------
    logic [5:0] sr_q;
    logic       u;
    logic [1:0] tx_sym;
    assign u      = enable_encoder_i & encoder_i;
    assign tx_sym = enc_sym(sr_q, u);

    // ---------------- channel ----------------
    logic [31:0] word_ct;
    logic [31:0] error_counter;
    logic [1:0]  err_inj;
    logic [1:0]  rx_q;

    // The error moves between c0 and c1 from one period to the next.
    always_comb begin
        err_inj = 2'b00;
        if (ERR_EN && ((word_ct & EP_M1) == EP_M1))
            err_inj = word_ct[EP_LOG] ? 2'b10 : 2'b01;
    end

    // ---------------- decoder ----------------
    logic [7:0]       pm_q [NS];
    logic [7:0]       pm_d [NS];
    logic [NS-1:0]    dec_d;
    logic [NS-1:0]    tb_mem_q [TBM];
    logic [PTR_W-1:0] wr_ptr_q;
    logic             tb_bit_q;
    logic [DL-1:0]    dl_q;
    logic             decoder_q;

    // The best state and the renormalisation offset both come from pm_q.
    // Because the comparison is strict, a tie keeps the lowest index.
    logic [7:0] min_pm;
    logic [5:0] best_s;
    logic       renorm;
    always_comb begin
        min_pm = pm_q[0];
        best_s = 6'd0;
        renorm = 1'b0;
        for (int s = 0; s < NS; s++) begin
            if (pm_q[s] < min_pm) begin
                min_pm = pm_q[s];
                best_s = 6'(s);
            end
            if (pm_q[s][7]) renorm = 1'b1;
        end
    end

    // A state holds the last six bits, newest bit in bit 0. The two
    // predecessors of state s differ only in the bit shifted out. On a tie
    // the lower-index predecessor p0 wins, so its decision bit is 0.
    logic [7:0] base;
    logic [5:0] sv, p0, p1;
    logic [7:0] m0, m1;
    always_comb begin
        base = renorm ? min_pm : 8'd0;
        sv = 6'd0;
        p0 = 6'd0;
        p1 = 6'd0;
        m0 = 8'd0;
        m1 = 8'd0;
        dec_d = '0;
        for (int s = 0; s < NS; s++) begin
            sv = 6'(s);
            p0 = {1'b0, sv[5:1]};
            p1 = {1'b1, sv[5:1]};
            m0 = sat_add(pm_q[p0] - base, hamming(rx_q ^ enc_sym(p0, sv[0])));
            m1 = sat_add(pm_q[p1] - base, hamming(rx_q ^ enc_sym(p1, sv[0])));
            dec_d[s] = (m1 < m0);
            pm_d[s]  = (m1 < m0) ? m1 : m0;
        end
    end

    // Start at the best current state and walk back TB_DEPTH rows, newest
    // row first. The state reached there carries its decoded bit in bit 0.
    logic [5:0] tb_st;
    int         ri;
    logic       tb_bit;
    always_comb begin
        tb_st = best_s;
        ri    = 0;
        for (int i = 0; i < TB_DEPTH; i++) begin
            ri = int'(wr_ptr_q) + TBM - 1 - i;
            if (ri >= TBM) ri = ri - TBM;
            tb_st = {tb_mem_q[PTR_W'(ri)][tb_st], tb_st[5:1]};
        end
        tb_bit = tb_st[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q          <= 6'd0;
            word_ct       <= 32'd0;
            error_counter <= 32'd0;
            rx_q          <= 2'b00;
            for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? 8'd0 : 8'hFF;
            for (int t = 0; t < TBM; t++) tb_mem_q[t] <= '0;
            wr_ptr_q      <= '0;
            tb_bit_q      <= 1'b0;
            dl_q          <= '0;
            decoder_q     <= 1'b0;
        end else begin
            sr_q    <= {sr_q[4:0], u};
            word_ct <= word_ct + 32'd1;
            if (err_inj != 2'b00) error_counter <= error_counter + 32'd1;
            rx_q    <= tx_sym ^ err_inj;
            for (int s = 0; s < NS; s++) pm_q[s] <= pm_d[s];
            tb_mem_q[wr_ptr_q] <= dec_d;
            wr_ptr_q  <= (wr_ptr_q == PTR_W'(TBM - 1)) ? '0 : wr_ptr_q + 1'b1;
            tb_bit_q  <= tb_bit;
            dl_q      <= {dl_q[DL-2:0], tb_bit_q};
            decoder_q <= dl_q[DL-1];
        end
    end

    assign decoder_o = decoder_q;
endmodule

// File: tb/tb_viterbi_tx_rx_2b7.sv
// Testbench for viterbi_tx_rx_2b7.
// Two instances run from the same inputs. One injects channel errors and
// the other has a clean channel. The reference is a plain delay: the output
// seen at edge k after a reset is the effective input bit (encoder_i AND
// enable_encoder_i) from edge k-LATENCY. Before that the output is 0.
// Edges are counted from the reset edge, which is edge 0.
module tb_viterbi_tx_rx_2b7;
    localparam int LAT = 4105;
    localparam int EP  = 16;

    logic clk = 1'b0;
    logic rst;
    logic encoder_i;
    logic enable_encoder_i;
    logic dec_o;
    logic dec_clean_o;

    int checks   = 0;
    int failures = 0;
    int edge_idx = 0;
    int last_k   = 0;
    bit last_ok  = 1'b0;
    logic hist[$];

    always #5 clk = ~clk;

    viterbi_tx_rx_2b7 #(.ERR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .encoder_i(encoder_i),
        .enable_encoder_i(enable_encoder_i), .decoder_o(dec_o)
    );

    viterbi_tx_rx_2b7 #(.ERR_EN(1'b0)) dut_clean (
        .clk(clk), .rst(rst), .encoder_i(encoder_i),
        .enable_encoder_i(enable_encoder_i), .decoder_o(dec_clean_o)
    );

    // Each call starts at a negedge. It checks the outputs that edge k will
    // sample, then drives the inputs for edge k and moves on one cycle.
    task automatic drive_cycle(input logic u, input logic en);
        logic exp;
        int k;
        k   = edge_idx + 1;
        exp = (k > LAT) ? hist[k - LAT - 1] : 1'b0;
        checks += 2;
        last_ok = (dec_o === exp);
        last_k  = k;
        if (dec_o !== exp) begin
            failures++;
            $display("FAIL decode edge=%0d got=%0b exp=%0b", k, dec_o, exp);
        end
        if (dec_clean_o !== exp) begin
            failures++;
            $display("FAIL decode_clean edge=%0d got=%0b exp=%0b", k, dec_clean_o, exp);
        end
        encoder_i = u;
        enable_encoder_i = en;
        hist.push_back(u & en);
        @(posedge clk);
        @(negedge clk);
        edge_idx++;
    endtask

    task automatic flush();
        repeat (LAT + 8) drive_cycle(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        encoder_i = 1'b0;
        enable_encoder_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        edge_idx = 0;
        checks += 4;
        if (dut.word_ct !== 32'd0) begin
            failures++;
            $display("FAIL reset_word_ct got=%0d exp=0", dut.word_ct);
        end
        if (dut.error_counter !== 32'd0) begin
            failures++;
            $display("FAIL reset_error_counter got=%0d exp=0", dut.error_counter);
        end
        if (dec_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_decoder_o got=%0b exp=0", dec_o);
        end
        if (dut.err_inj !== 2'b00) begin
            failures++;
            $display("FAIL reset_err_inj got=%0b exp=00", dut.err_inj);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    // All-zero input. At every slot where word_ct = 15 mod 16 the bench
    // also checks which symbol bit the channel flips.
    task automatic test_all_zero();
        logic [1:0] exp_mask;
        do_reset();
        repeat (5000) begin
            if ((edge_idx % EP) == EP - 1) begin
                exp_mask = (((edge_idx / EP) % 2) == 0) ? 2'b01 : 2'b10;
                checks++;
                if (dut.err_inj !== exp_mask) begin
                    failures++;
                    $display("FAIL err_inj word_ct=%0d got=%b exp=%b", edge_idx, dut.err_inj, exp_mask);
                end
            end
            drive_cycle(1'b0, 1'b1);
        end
        checks += 2;
        if (dut.error_counter !== 32'(edge_idx / EP)) begin
            failures++;
            $display("FAIL zero_error_counter got=%0d exp=%0d", dut.error_counter, edge_idx / EP);
        end
        if (dut_clean.error_counter !== 32'd0) begin
            failures++;
            $display("FAIL zero_clean_error_counter got=%0d exp=0", dut_clean.error_counter);
        end
    endtask

    // Runs of growing length, then single-cycle toggles; the sequence is
    // sent twice and padded to 256 bits.
    task automatic test_pattern();
        logic pat[$];
        int good = 0;
        int bad = 0;
        for (int r = 0; r < 2; r++) begin
            pat.push_back(1'b1);
            pat.push_back(1'b0);
            for (int l = 2; l <= 10; l++) begin
                repeat (l) pat.push_back(1'b0);
                repeat (l) pat.push_back(1'b1);
            end
            for (int t = 0; t < 16; t++) pat.push_back(t[0] ? 1'b0 : 1'b1);
        end
        while (pat.size() < 256) pat.push_back(pat.size() % 2 == 0 ? 1'b1 : 1'b0);
        do_reset();
        foreach (pat[i]) drive_cycle(pat[i], 1'b1);
        repeat (LAT + 8) begin
            drive_cycle(1'b0, 1'b1);
            if (last_k - LAT >= 1 && last_k - LAT <= 256) begin
                if (last_ok) good++;
                else bad++;
            end
        end
        checks++;
        if (good != 256 || bad != 0) begin
            failures++;
            $display("FAIL pattern_tally good=%0d bad=%0d exp good=256 bad=0", good, bad);
        end
    endtask

    task automatic test_runs_random();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            repeat ((r % 2 == 0) ? 10 : 100) drive_cycle(r[1], 1'b1);
            repeat (20) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
        end
        flush();
    endtask

    task automatic test_clean_channel();
        do_reset();
        repeat (300) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
        flush();
        checks++;
        if (dut_clean.error_counter !== 32'd0) begin
            failures++;
            $display("FAIL clean_error_counter got=%0d exp=0", dut_clean.error_counter);
        end
    endtask

    // While enable is low, encoder_i keeps toggling; the reference sees 0.
    task automatic test_enable_low();
        do_reset();
        repeat (50) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 100; i++) drive_cycle(i[0], 1'b0);
        repeat (50) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
        flush();
    endtask

    // A reset in the middle of traffic: no bit sent before it may come out.
    task automatic test_mid_reset();
        do_reset();
        repeat (2000) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
        do_reset();
        repeat (300) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
        flush();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        encoder_i = 1'b0;
        enable_encoder_i = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_all_zero();
        test_pattern();
        test_runs_random();
        test_clean_channel();
        test_enable_low();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
